// File: rtl/pulse_stretch_multi_if.sv
// Event/status bundle between the fast-domain event sources and the pulse stretcher.
// Latency: none (wires only). Backpressure: none; busy/drop report channel occupancy and loss.
interface pulse_stretch_multi_if #(
    parameter int CH = 4
);
    logic [CH-1:0] pulse_in;
    logic [CH-1:0] drop_clr;
    logic [CH-1:0] pulse_out;
    logic [CH-1:0] busy;
    logic [CH-1:0] drop;

    modport master (
        output pulse_in,
        output drop_clr,
        input  pulse_out,
        input  busy,
        input  drop
    );

    modport slave (
        input  pulse_in,
        input  drop_clr,
        output pulse_out,
        output busy,
        output drop
    );
endinterface

// File: rtl/pulse_stretch_multi.sv
// Per-channel fast-to-slow pulse stretcher: STRETCH-cycle high pulse then GAP-cycle low gap per event.
// Latency: input rise before edge k -> pulse_out high from edge k+1; busy rises at edge k.
// Backpressure: none; events arriving while busy are queued (PULSE_QUEUE_EN) or dropped, flagged on drop.
module pulse_stretch_multi #(
    parameter int CH      = 4,
    parameter int STRETCH = 12,
    parameter int GAP     = 4,
    parameter int QDEPTH  = 3
) (
    input  logic                  clka,
    input  logic                  rst_n,
    pulse_stretch_multi_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam int CMAX = (STRETCH > GAP) ? STRETCH : GAP;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] CNT_HIGH = CW'(STRETCH - 1);
    localparam logic [CW-1:0] CNT_GAP  = CW'(GAP - 1);

    if (STRETCH < 1 || GAP < 1 || QDEPTH < 1) begin : g_param_chk
        $error("pulse_stretch_multi: STRETCH, GAP and QDEPTH must all be >= 1");
    end

    logic [CH-1:0] pulse_in_q;
    logic [CH-1:0] ev;
    logic [CH-1:0] pulse_q, pulse_d;
    logic [CH-1:0] busy_q, busy_d;
    logic [CH-1:0] drop_q, drop_d;
    state_t        state_q [CH];
    state_t        state_d [CH];
    logic [CW-1:0] cnt_q   [CH];
    logic [CW-1:0] cnt_d   [CH];

`ifdef PULSE_QUEUE_EN
    localparam int PW = $clog2(QDEPTH + 1);
    localparam logic [PW-1:0] PEND_MAX = PW'(QDEPTH);
    logic [PW-1:0] pend_q [CH];
    logic [PW-1:0] pend_d [CH];
    logic [CH-1:0] deq;
    logic [CH-1:0] enq;
`endif

    // One event per low-to-high transition; a held level does not retrigger.
    assign ev = bus.pulse_in & ~pulse_in_q;

    always_comb begin
        for (int i = 0; i < CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            drop_d[i]  = drop_q[i] & ~bus.drop_clr[i];
`ifdef PULSE_QUEUE_EN
            pend_d[i]  = pend_q[i];
            deq[i]     = 1'b0;
            enq[i]     = 1'b0;
`endif
            case (state_q[i])
                ST_IDLE: begin
                    if (ev[i]) begin
                        state_d[i] = ST_HIGH;
                        cnt_d[i]   = CNT_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (cnt_q[i] == '0) begin
                        state_d[i] = ST_GAP;
                        cnt_d[i]   = CNT_GAP;
                    end else begin
                        cnt_d[i]   = cnt_q[i] - CW'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt_q[i] == '0) begin
`ifdef PULSE_QUEUE_EN
                        if (pend_q[i] != '0) begin
                            state_d[i] = ST_HIGH;
                            cnt_d[i]   = CNT_HIGH;
                            deq[i]     = 1'b1;
                        end else begin
                            state_d[i] = ST_IDLE;
                        end
`else
                        state_d[i] = ST_IDLE;
`endif
                    end else begin
                        cnt_d[i]   = cnt_q[i] - CW'(1);
                    end
                end
                default: begin
                    state_d[i] = ST_IDLE;
                    cnt_d[i]   = '0;
                end
            endcase

            // An event landing while the channel is occupied, including its final gap cycle.
            if (ev[i] && (state_q[i] != ST_IDLE)) begin
`ifdef PULSE_QUEUE_EN
                if (!deq[i] && (pend_q[i] == PEND_MAX)) begin
                    drop_d[i] = 1'b1;
                end else begin
                    enq[i] = 1'b1;
                end
`else
                drop_d[i] = 1'b1;
`endif
            end

`ifdef PULSE_QUEUE_EN
            // Simultaneous enqueue and dequeue leave the count unchanged.
            if (enq[i] && !deq[i]) begin
                pend_d[i] = pend_q[i] + PW'(1);
            end else if (deq[i] && !enq[i]) begin
                pend_d[i] = pend_q[i] - PW'(1);
            end
            busy_d[i] = (state_d[i] != ST_IDLE) || (pend_d[i] != '0);
`else
            busy_d[i] = (state_d[i] != ST_IDLE);
`endif
            pulse_d[i] = (state_q[i] == ST_HIGH);
        end
    end

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            pulse_in_q <= '0;
            pulse_q    <= '0;
            busy_q     <= '0;
            drop_q     <= '0;
            for (int i = 0; i < CH; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
`ifdef PULSE_QUEUE_EN
                pend_q[i]  <= '0;
`endif
            end
        end else begin
            pulse_in_q <= bus.pulse_in;
            pulse_q    <= pulse_d;
            busy_q     <= busy_d;
            drop_q     <= drop_d;
            for (int i = 0; i < CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
`ifdef PULSE_QUEUE_EN
                pend_q[i]  <= pend_d[i];
`endif
            end
        end
    end

    assign bus.pulse_out = pulse_q;
    assign bus.busy      = busy_q;
    assign bus.drop      = drop_q;

endmodule
